// File: rtl/float_add_issue.sv
// float_add_issue: FIFO-buffered issue/return sequencer for an external FP adder
module float_add_issue #(
  parameter int DEPTH       = 4,
  parameter int ADD_LATENCY = 1,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             req_negate,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_negate,
  output logic             add_enable,
  input  logic [31:0]      add_out,
  output logic             busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(ADD_LATENCY + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [31:0]      mem_a_q [DEPTH];
  logic [31:0]      mem_b_q [DEPTH];
  logic             mem_n_q [DEPTH];
  logic [TAG_W-1:0] mem_t_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      add_a_q, add_b_q, resp_data_q;
  logic             add_negate_q, add_enable_q, resp_valid_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic             push, pop, cap, has_req;

  assign req_ready  = count_q < CW'(DEPTH);
  assign push       = req_valid && req_ready;
  assign has_req    = count_q != '0;
  // A pop happens from IDLE, or from HOLD as the held result is accepted, so HOLD can chain straight into ISSUE.
  assign pop        = has_req && (state_q == S_IDLE || (state_q == S_HOLD && resp_ready));
  assign cap        = state_q == S_WAIT && lat_q == LW'(1);
  assign busy       = state_q != S_IDLE || has_req;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_negate = add_negate_q;
  assign add_enable = add_enable_q;

  // Next-state for the sequencer, latency counter and FIFO occupancy.
  always_comb begin
    state_d = pop ? S_ISSUE :
              state_q == S_ISSUE ? S_WAIT :
              cap ? S_HOLD :
              (state_q == S_HOLD && resp_ready) ? S_IDLE : state_q;
    lat_d   = state_q == S_ISSUE ? LW'(ADD_LATENCY) :
              state_q == S_WAIT ? lat_q - LW'(1) : lat_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Queue storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wptr_q] <= req_a;
      mem_b_q[wptr_q] <= req_b;
      mem_n_q[wptr_q] <= req_negate;
      mem_t_q[wptr_q] <= req_tag;
    end
  end

  // Control, issue and response registers; the enable pulse is registered from the pop decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      lat_q        <= '0;
      tag_q        <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_negate_q <= 1'b0;
      add_enable_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wptr_q       <= wptr_q + PW'(push);
      rptr_q       <= rptr_q + PW'(pop);
      lat_q        <= lat_d;
      add_enable_q <= pop;
      resp_valid_q <= cap || (resp_valid_q && !resp_ready);
      if (pop) begin
        add_a_q      <= mem_a_q[rptr_q];
        add_b_q      <= mem_b_q[rptr_q];
        add_negate_q <= mem_n_q[rptr_q];
        tag_q        <= mem_t_q[rptr_q];
      end
      if (cap) begin
        resp_data_q <= add_out;
        resp_tag_q  <= tag_q;
      end
    end
  end
endmodule

// File: tb/tb_float_add_issue.sv
// tb_float_add_issue: vector, corner-case and randomized scoreboard checks for float_add_issue
module tb_float_add_issue;
  localparam int L = 1;

  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready, req_negate = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic [3:0]  req_tag = 0;
  logic        resp_valid, resp_ready = 0;
  logic [31:0] resp_data;
  logic [3:0]  resp_tag;
  logic [31:0] add_a, add_b, add_out = 0;
  logic        add_negate, add_enable, busy;

  float_add_issue #(.DEPTH(4), .ADD_LATENCY(L), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_negate(req_negate), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .add_a(add_a), .add_b(add_b), .add_negate(add_negate),
    .add_enable(add_enable), .add_out(add_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, en_cnt = 0, resp_cnt = 0;
  typedef struct { logic [31:0] d; logic [3:0] t; } exp_t;
  typedef struct { logic [31:0] a, b; logic n; logic [3:0] t; logic [31:0] e; } vec_t;
  exp_t exp_q[$];
  logic [3:0] rtags[$];
  int en_cyc[$];
  vec_t vt[6];

  function automatic real s2d(logic [31:0] s);
    if (s[30:0] == 0) return 0.0;
    return $bitstoreal({s[31], 11'(int'(s[30:23]) + 896), s[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] d2s(real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 0) return 32'h0;
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b, logic n);
    return d2s(n ? s2d(a) - s2d(b) : s2d(a) + s2d(b));
  endfunction

  function automatic logic [31:0] i2f(int v);
    return d2s(real'(v));
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Adder stand-in: result appears the edge after the enable cycle and holds.
  always @(posedge clk) if (add_enable) add_out <= fadd(add_a, add_b, add_negate);

  // Scoreboard: every accepted request expects one in-order result.
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (add_enable) begin
        en_cnt++;
        en_cyc.push_back(cyc);
      end
      if (resp_valid && resp_ready) begin
        resp_cnt++;
        rtags.push_back(resp_tag);
        if (exp_q.size() == 0) chk("unexpected_resp", 32'(resp_tag), 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_data", resp_data, e.d);
          chk("sb_tag", 32'(resp_tag), 32'(e.t));
        end
      end
      if (req_valid && req_ready) exp_q.push_back('{fadd(req_a, req_b, req_negate), req_tag});
    end
  end

  task automatic drive(logic [31:0] a, logic [31:0] b, logic n, logic [3:0] t);
    req_valid = 1; req_a = a; req_b = b; req_negate = n; req_tag = t;
  endtask

  task automatic single(vec_t v);
    int c0, en_c, rv_c;
    logic neg_seen;
    logic [31:0] d;
    logic [3:0] t;
    en_c = -1; rv_c = -1; neg_seen = 0; d = 0; t = 0;
    @(posedge clk); #1;
    drive(v.a, v.b, v.n, v.t);
    c0 = cyc;
    @(posedge clk); #1;
    req_valid = 0;
    for (int k = 0; k < 20 && rv_c < 0; k++) begin
      @(negedge clk);
      if (add_enable) begin en_c = cyc; neg_seen = add_negate; end
      if (resp_valid) begin rv_c = cyc; d = resp_data; t = resp_tag; end
    end
    chk("enable_latency", 32'(en_c - c0), 32'd2);
    chk("resp_latency", 32'(rv_c - c0), 32'(3 + L));
    chk("issue_negate", 32'(neg_seen), 32'(v.n));
    chk("vec_data", d, v.e);
    chk("vec_tag", 32'(t), 32'(v.t));
  endtask

  task automatic drain(int bound);
    int k;
    k = 0;
    req_valid = 0;
    resp_ready = 1;
    while ((busy || resp_valid) && k < bound) begin @(negedge clk); k++; end
    chk("drain_timeout", 32'(busy || resp_valid), 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc, e0, r0;
    logic [31:0] hd;
    logic [3:0] ht;
    vt[0] = '{32'h3F800000, 32'h40000000, 1'b0, 4'd3, 32'h40400000};
    vt[1] = '{32'h40400000, 32'h3F800000, 1'b1, 4'd7, 32'h40000000};
    vt[2] = '{32'h3FC00000, 32'h40200000, 1'b0, 4'd1, 32'h40800000};
    vt[3] = '{32'h40000000, 32'h40000000, 1'b1, 4'd9, 32'h00000000};
    vt[4] = '{32'h41200000, 32'hC0400000, 1'b0, 4'd15, 32'h40E00000};
    vt[5] = '{32'h40A00000, 32'hC0A00000, 1'b1, 4'd0, 32'h41200000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_add_enable", 32'(add_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_tag", 32'(resp_tag), 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_negate", 32'(add_negate), 0);
    @(posedge clk); #1;
    reset = 0;
    resp_ready = 1;

    foreach (vt[i]) single(vt[i]);
    drain(20);

    // Back-pressure: six offers with responses stalled, five fit.
    resp_ready = 0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(i2f($urandom_range(2000) - 1000), i2f($urandom_range(2000) - 1000), 1'($urandom), 4'(i));
      @(negedge clk);
      if (req_ready) acc++;
    end
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp_accepted", 32'(acc), 32'd5);
    @(negedge clk);
    chk("bp_req_ready", 32'(req_ready), 0);
    repeat (4) @(negedge clk);
    chk("bp_resp_valid", 32'(resp_valid), 1);
    hd = resp_data; ht = resp_tag;
    chk("bp_first_tag", 32'(ht), 0);
    repeat (5) @(negedge clk);
    chk("bp_hold_data", resp_data, hd);
    chk("bp_hold_tag", 32'(resp_tag), 32'(ht));
    rtags.delete();
    e0 = en_cnt; r0 = resp_cnt;
    @(posedge clk); #1;
    drain(100);
    chk("bp_resp_count", 32'(resp_cnt - r0), 32'd5);
    chk("bp_enable_count", 32'(en_cnt - e0), 32'd4);
    chk("bp_tag_count", 32'(rtags.size()), 32'd5);
    if (rtags.size() == 5) foreach (rtags[i]) chk("bp_tag_order", 32'(rtags[i]), 32'(i));

    // Back-to-back: three queued requests chain HOLD straight into ISSUE.
    en_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(i2f(i + 1), i2f(10 * i), 1'b0, 4'(8 + i));
    end
    @(posedge clk); #1;
    req_valid = 0;
    drain(60);
    chk("b2b_enables", 32'(en_cyc.size()), 32'd3);
    if (en_cyc.size() == 3) begin
      chk("b2b_gap0", 32'(en_cyc[1] - en_cyc[0]), 32'(L + 2));
      chk("b2b_gap1", 32'(en_cyc[2] - en_cyc[1]), 32'(L + 2));
    end

    // Reset while the first of three is in WAIT and two remain queued.
    r0 = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(i2f(5), i2f(i), 1'b0, 4'(12 + i));
    end
    @(posedge clk); #1;
    req_valid = 0;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_resp_valid", 32'(resp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 1);
    chk("mid_rst_add_enable", 32'(add_enable), 0);
    acc = 0;
    repeat (20) begin @(negedge clk); if (resp_valid || add_enable) acc++; end
    chk("mid_rst_no_resp", 32'(acc), 0);
    chk("mid_rst_resp_count", 32'(resp_cnt - r0), 0);

    // FIFO wrap: ten sequential singles with distinct tags.
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v.a = i2f($urandom_range(2000) - 1000);
      v.b = i2f($urandom_range(2000) - 1000);
      v.n = 1'($urandom);
      v.t = 4'(i);
      v.e = fadd(v.a, v.b, v.n);
      single(v);
    end
    drain(20);

    // Randomized traffic with random back-pressure against the scoreboard.
    r0 = resp_cnt;
    acc = 0;
    repeat (400) begin
      @(posedge clk); #1;
      drive(i2f($urandom_range(2000) - 1000), i2f($urandom_range(2000) - 1000),
            1'($urandom), 4'($urandom));
      req_valid = ($urandom_range(2) != 0);
      resp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (req_valid && req_ready) acc++;
    end
    @(posedge clk); #1;
    drain(200);
    chk("rand_one_resp_each", 32'(resp_cnt - r0), 32'(acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
